// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   rs_state_t : sequencer FSM states
//   cnt_w()    : width of the hold/stagger cycle counter
//   MAX_CH     : largest supported channel count
package reset_seq_pkg;

  localparam int unsigned MAX_CH = 16;

  typedef enum logic [1:0] {
    ASSERT,
    HOLD,
    STAGGER,
    RUN
  } rs_state_t;

  // Counter must reach max(hold, stagger)-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned hold, input int unsigned stagger);
    int unsigned m;
    m = (hold > stagger) ? hold : stagger;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Async-assert / sync-release reset synchronizer.
//   clock    : system clock
//   reset    : raw async reset, active-high
//   rst_sync : synchronized reset, deasserts on the STAGES-th rising edge
//              after reset falls
module reset_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  output logic rst_sync
);

  logic [STAGES-1:0] chain;

  // Shift zeros in once reset is gone; any reset reloads ones at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered per-channel reset generator with per-channel clock-enable ticks.
// Channels leave reset in order 0..NUM_CH-1, STAGGER_CYCLES apart, after the
// synchronized reset release plus HOLD_CYCLES.
//   clock      : system clock
//   reset      : async reset, active-high
//   soft_reset : synchronous re-sequence request (only with SOFT_RESET_EN)
//   div        : per-channel divisor, channel k at [k*DIV_WIDTH +: DIV_WIDTH]
//   rst_out    : per-channel reset, active-high, registered
//   clk_en     : per-channel single-cycle enable tick, registered
//   seq_done   : every channel is out of reset
// Build option: define SOFT_RESET_EN to honour soft_reset.
module reset_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned DIV_WIDTH      = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          soft_reset,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   div,
  output logic [NUM_CH-1:0]             rst_out,
  output logic [NUM_CH-1:0]             clk_en,
  output logic                          seq_done
);

  import reset_seq_pkg::*;

  localparam int unsigned CW  = cnt_w(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0]  HOLD_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CW-1:0]  STAG_LAST = CW'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CH - 1);

  rs_state_t         state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [CHW-1:0]    ch, ch_nxt;
  logic [NUM_CH-1:0] rst_nxt;
  logic              done_nxt;
  logic              rel_first;
  logic              rst_sync;
  logic              soft_hit;

  reset_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .rst_sync (rst_sync)
  );

`ifdef SOFT_RESET_EN
  assign soft_hit = soft_reset;
`else
  // Port kept for a stable interface; it has no effect in this build.
  logic unused_soft;
  assign unused_soft = soft_reset;
  assign soft_hit    = 1'b0;
`endif

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    rst_nxt   = rst_out;
    rel_first = 1'b0;

    case (state)
      ASSERT: begin
        cnt_nxt = '0;
        ch_nxt  = '0;
        if (!rst_sync) begin
          // Zero hold releases channel 0 on the edge that would enter HOLD.
          if (HOLD_CYCLES == 0) rel_first = 1'b1;
          else                  state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) rel_first = 1'b1;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      STAGGER: begin
        if (cnt == STAG_LAST) begin
          rst_nxt[ch] = 1'b0;
          cnt_nxt     = '0;
          if (ch == LAST_CH) state_nxt = RUN;
          else               ch_nxt    = ch + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
      end
      default: state_nxt = ASSERT;
    endcase

    // Channel 0 release; with no stagger (or one channel) everything goes.
    if (rel_first) begin
      cnt_nxt = '0;
      if ((NUM_CH == 1) || (STAGGER_CYCLES == 0)) begin
        rst_nxt   = '0;
        state_nxt = RUN;
      end else begin
        rst_nxt[0] = 1'b0;
        ch_nxt     = CHW'(1);
        state_nxt  = STAGGER;
      end
    end

    // Soft reset bypasses the synchronizer: rst_sync is already low.
    if (soft_hit) begin
      state_nxt = ASSERT;
      cnt_nxt   = '0;
      ch_nxt    = '0;
      rst_nxt   = '1;
    end

    done_nxt = (state_nxt == RUN);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ASSERT;
      cnt      <= '0;
      ch       <= '0;
      rst_out  <= '1;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ch       <= ch_nxt;
      rst_out  <= rst_nxt;
      seq_done <= done_nxt;
    end
  end

  // Per-channel enable dividers, held clear while the channel is in reset.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_div
    logic [DIV_WIDTH-1:0] dval;
    logic [DIV_WIDTH-1:0] dcnt;
    logic                 wrap;
    logic                 tick;

    assign dval = div[k*DIV_WIDTH +: DIV_WIDTH];
    // >= rather than == so a divisor lowered mid-count wraps right away.
    assign wrap = (dval <= DIV_WIDTH'(1)) || (dcnt >= (dval - DIV_WIDTH'(1)));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dcnt <= '0;
        tick <= 1'b0;
      end else if (rst_out[k] || soft_hit) begin
        dcnt <= '0;
        tick <= 1'b0;
      end else begin
        tick <= wrap;
        dcnt <= wrap ? '0 : dcnt + 1'b1;
      end
    end

    assign clk_en[k] = tick;
  end

endmodule
